// File: rtl/sub16_serial_pkg.sv
// Shared types and sizing constants for the bit-serial subtractor.
package sub16_serial_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned CNT_W_DEF = $clog2(WIDTH_DEF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sub16_serial_full_adder_bit.sv
// One-bit combinational full adder used as the serial datapath slice.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/sub16_serial.sv
// Bit-serial subtractor: diff = A + ~B + 1, LSB first, one bit per clock,
// with a start/ready/done handshake and registered result flags.
module sub16_serial
  import sub16_serial_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             zero
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [WIDTH-1:0]   sha;
  logic [WIDTH-1:0]   shb;
  logic [WIDTH-2:0]   res;
  logic [CNT_W-1:0]   cnt;
  logic               carry;
  logic               sa;
  logic               sb;
  logic               fa_s;
  logic               fa_cout;
  logic [WIDTH-1:0]   nxt;

  full_adder_bit u_fa (
    .a    (sha[0]),
    .b    (shb[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // Result register keeps only the already-produced bits; the final bit joins
  // them directly on the way into diff.
  always_comb begin
    nxt = {fa_s, res};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      ready    <= 1'b1;
      done     <= 1'b0;
      diff     <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      sha      <= '0;
      shb      <= '0;
      res      <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      sa       <= 1'b0;
      sb       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            sha   <= A;
            shb   <= ~B;
            carry <= 1'b1;
            cnt   <= '0;
            sa    <= A[WIDTH-1];
            sb    <= B[WIDTH-1];
            ready <= 1'b0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          sha   <= sha >> 1;
          shb   <= shb >> 1;
          carry <= fa_cout;
          res   <= nxt[WIDTH-1:1];
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            state    <= ST_DONE;
            done     <= 1'b1;
            diff     <= nxt;
            borrow   <= ~fa_cout;
            overflow <= (sa != sb) && (fa_s != sa);
            zero     <= (nxt == '0);
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub16_serial.sv
// Self-checking bench for sub16_serial: directed vectors, handshake corner
// cases and a randomized back-to-back run against an arithmetic model.
module tb_sub16_serial;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        ready;
  logic        done;
  logic [15:0] diff;
  logic        borrow;
  logic        overflow;
  logic        zero;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  sub16_serial #(.WIDTH(16), .CNT_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .A        (A),
    .B        (B),
    .ready    (ready),
    .done     (done),
    .diff     (diff),
    .borrow   (borrow),
    .overflow (overflow),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] d;
    logic        bo;
    logic        ov;
    logic        z;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, edge_n);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic model(input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] d, output logic bo,
                       output logic ov, output logic z);
    int sd;
    d  = 16'(a - b);
    bo = (a < b);
    sd = int'($signed(a)) - int'($signed(b));
    ov = (sd > 32767) || (sd < -32768);
    z  = (d == 16'h0000);
  endtask

  // Single accepted operation; returns edges from start to done and checks
  // that ready stays low throughout.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, output int lat);
    int n;
    A = a;
    B = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    A = ~a;
    B = a;
    chk("ready_low_after_accept", {31'd0, ready}, 32'd0);
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
      if (!done && ready) chk("ready_low_during_run", {31'd0, ready}, 32'd0);
    end
    lat = n;
    if (n >= 40) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int lat;
    int pulses;
    int last_done;
    logic [15:0] ed;
    logic eb, eo, ez;
    logic [15:0] ra, rb;

    vecs[0] = '{16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{16'hAAAA, 16'hAAAA, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1, 1'b0};

    reset = 1'b1;
    start = 1'b1;
    A = 16'h1234;
    B = 16'h0001;
    tick();
    tick();
    chk("reset_ready", {31'd0, ready}, 32'd1);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_diff", {16'd0, diff}, 32'd0);
    chk("reset_flags", {29'd0, borrow, overflow, zero}, 32'd0);
    reset = 1'b0;
    start = 1'b0;
    tick();

    // Directed table
    for (int i = 0; i < 5; i++) begin
      run_op(vecs[i].a, vecs[i].b, lat);
      chk("latency", lat, 32'd16);
      chk("vec_diff", {16'd0, diff}, {16'd0, vecs[i].d});
      chk("vec_borrow", {31'd0, borrow}, {31'd0, vecs[i].bo});
      chk("vec_overflow", {31'd0, overflow}, {31'd0, vecs[i].ov});
      chk("vec_zero", {31'd0, zero}, {31'd0, vecs[i].z});
      tick();
      chk("done_one_cycle", {31'd0, done}, 32'd0);
      chk("ready_back", {31'd0, ready}, 32'd1);
      chk("diff_hold", {16'd0, diff}, {16'd0, vecs[i].d});
      tick();
    end

    // Start pulsed mid-RUN must be ignored
    A = 16'h00FF;
    B = 16'h000F;
    start = 1'b1;
    tick();
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 5) begin
        A = 16'h1234;
        B = 16'h1111;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      if (done) begin
        pulses++;
        chk("midrun_diff", {16'd0, diff}, 32'h00F0);
      end
    end
    chk("midrun_pulses", pulses, 32'd1);

    // Reset in the middle of RUN discards the operation
    A = 16'h0005;
    B = 16'h0003;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset_ready", {31'd0, ready}, 32'd1);
    chk("midreset_diff", {16'd0, diff}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done) pulses++;
    end
    chk("midreset_no_done", pulses, 32'd0);
    run_op(16'h0010, 16'h0001, lat);
    chk("post_reset_diff", {16'd0, diff}, 32'h000F);
    tick();

    // Randomized back-to-back with start held high
    start = 1'b1;
    last_done = -1;
    for (int i = 0; i < 200; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 17 == 0) rb = ra;
      A = ra;
      B = rb;
      lat = 0;
      while (!ready && lat < 40) begin
        tick();
        lat++;
      end
      if (lat >= 40) chk("rand_ready_timeout", 32'd0, 32'd1);
      tick();
      A = 16'($urandom);
      B = 16'($urandom);
      lat = 0;
      while (!done && lat < 40) begin
        tick();
        lat++;
      end
      if (lat >= 40) chk("rand_done_timeout", 32'd0, 32'd1);
      model(ra, rb, ed, eb, eo, ez);
      chk("rand_diff", {16'd0, diff}, {16'd0, ed});
      chk("rand_flags", {29'd0, borrow, overflow, zero}, {29'd0, eb, eo, ez});
      chk("rand_add_back", {16'd0, 16'(diff + rb)}, {16'd0, ra});
      if (last_done >= 0) chk("rand_spacing", edge_n - last_done, 32'd18);
      last_done = edge_n;
      tick();
    end
    start = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
